// File: rtl/sevenseg_scan_mux.sv
// sevenseg_scan_mux: N-digit multiplexed 7-seg driver with frame latch, LZ blanking, PWM; SEVENSEG_DP_EN adds decimal points
module sevenseg_scan_mux #(
  parameter int NUM_DIGITS = 4,
  parameter int BRIGHT_W   = 3
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    scan_en,
  input  logic [4*NUM_DIGITS-1:0] digits,
  input  logic                    lz_en,
  input  logic [BRIGHT_W-1:0]     brightness,
`ifdef SEVENSEG_DP_EN
  input  logic [NUM_DIGITS-1:0]   dp_in,
  output logic                    dp_n,
`endif
  output logic [NUM_DIGITS-1:0]   an,
  output logic [6:0]              seg,
  output logic                    frame_done
);
  localparam int IW = $clog2(NUM_DIGITS);
  localparam logic [IW-1:0] LAST = IW'(NUM_DIGITS - 1);
  logic [BRIGHT_W-1:0]     sub;
  logic [IW-1:0]           idx;
  logic [4*NUM_DIGITS-1:0] sh_digits;
  logic                    sh_lz;
  logic [BRIGHT_W-1:0]     sh_bright;
  logic                    load_pending;
  logic [NUM_DIGITS-1:0]   blank;
  logic                    seen;
  logic [3:0]              code;
  logic                    latch;
  logic                    on;
`ifdef SEVENSEG_DP_EN
  logic [NUM_DIGITS-1:0]   sh_dp;
`endif
  assign latch = scan_en && (load_pending || (&sub && idx == LAST));
  assign code  = sh_digits[{idx, 2'b00} +: 4];
  assign on    = sub <= sh_bright;
  function automatic logic [6:0] dec(input logic [3:0] c);
    case (c)
      4'h0: dec = 7'h40;
      4'h1: dec = 7'h79;
      4'h2: dec = 7'h24;
      4'h3: dec = 7'h30;
      4'h4: dec = 7'h19;
      4'h5: dec = 7'h12;
      4'h6: dec = 7'h02;
      4'h7: dec = 7'h78;
      4'h8: dec = 7'h00;
      4'h9: dec = 7'h10;
      4'hA: dec = 7'h08;
      4'hB: dec = 7'h03;
      4'hC: dec = 7'h46;
      4'hD: dec = 7'h21;
      4'hE: dec = 7'h06;
      default: dec = 7'h7F;
    endcase
  endfunction
  // blank leading 0/F codes from the most significant digit down; digit 0 always shown
  always_comb begin
    seen  = 1'b0;
    blank = '0;
    for (int i = NUM_DIGITS - 1; i > 0; i--) begin
      blank[i] = sh_lz && !seen && (sh_digits[4*i +: 4] == 4'h0 || sh_digits[4*i +: 4] == 4'hF);
      seen = seen | (sh_digits[4*i +: 4] != 4'h0 && sh_digits[4*i +: 4] != 4'hF);
    end
  end
  // scan counters and shadow frame, all advancing only on the scan tick
  always_ff @(posedge clk) begin
    if (rst) begin
      sub          <= '0;
      idx          <= '0;
      sh_digits    <= '1;
      sh_lz        <= 1'b0;
      sh_bright    <= '0;
      load_pending <= 1'b1;
      frame_done   <= 1'b0;
`ifdef SEVENSEG_DP_EN
      sh_dp        <= '0;
`endif
    end else begin
      frame_done <= latch;
      if (scan_en) begin
        sub <= sub + 1'b1;
        if (&sub) idx <= (idx == LAST) ? '0 : idx + 1'b1;
      end
      if (latch) begin
        sh_digits    <= digits;
        sh_lz        <= lz_en;
        sh_bright    <= brightness;
        load_pending <= 1'b0;
`ifdef SEVENSEG_DP_EN
        sh_dp        <= dp_in;
`endif
      end
    end
  end
  // registered display outputs derived from the current scan position
  always_ff @(posedge clk) begin
    if (rst) begin
      an   <= '1;
      seg  <= 7'h7F;
`ifdef SEVENSEG_DP_EN
      dp_n <= 1'b1;
`endif
    end else begin
      an   <= on ? ~(NUM_DIGITS'(1) << idx) : '1;
      seg  <= blank[idx] ? 7'h7F : dec(code);
`ifdef SEVENSEG_DP_EN
      dp_n <= on ? ~sh_dp[idx] : 1'b1;
`endif
    end
  end
endmodule

// File: tb/tb_sevenseg_scan_mux.sv
// tb_sevenseg_scan_mux: directed-vector self-checking bench for sevenseg_scan_mux (4 digits, 2-bit brightness)
module tb_sevenseg_scan_mux;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        scan_en = 1'b1;
  logic        lz_en = 1'b0;
  logic [15:0] digits = 16'hFF10;
  logic [1:0]  brightness = 2'd3;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        frame_done;
  int          checks = 0;
  int          failures = 0;
`ifdef SEVENSEG_DP_EN
  logic [3:0]  dp_in = 4'b0000;
  logic        dp_n;
`endif
  sevenseg_scan_mux #(.NUM_DIGITS(4), .BRIGHT_W(2)) dut (
    .clk(clk),
    .rst(rst),
    .scan_en(scan_en),
    .digits(digits),
    .lz_en(lz_en),
    .brightness(brightness),
`ifdef SEVENSEG_DP_EN
    .dp_in(dp_in),
    .dp_n(dp_n),
`endif
    .an(an),
    .seg(seg),
    .frame_done(frame_done)
  );
  always #5 clk = ~clk;
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic sync_frame;
    logic got;
    got = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      tick;
      got = frame_done;
    end
    chk("sync", 32'(got), 32'd1);
  endtask
  task automatic check_frame(input logic [6:0] e0, input logic [6:0] e1, input logic [6:0] e2,
                             input logic [6:0] e3, input int br, input int cj, input logic [15:0] nd);
    logic [6:0] e[4];
    logic [3:0] ea;
    e = '{e0, e1, e2, e3};
    for (int j = 0; j < 16; j++) begin
      tick;
      ea = (j % 4 <= br) ? ~(4'b0001 << (j / 4)) : 4'hF;
      chk("an", 32'(an), 32'(ea));
      chk("seg", 32'(seg), 32'(e[j/4]));
      chk("frame_done", 32'(frame_done), (j == 15) ? 32'd1 : 32'd0);
      if (j == cj) digits = nd;
    end
  endtask
  task automatic load(input logic [15:0] d, input logic lz, input logic [1:0] br);
    digits = d;
    lz_en = lz;
    brightness = br;
    sync_frame;
  endtask
  initial begin
    logic [6:0] e6[4];
    logic [3:0] ea;
    int t;
    repeat (3) tick;
    chk("rst_an", 32'(an), 32'hF);
    chk("rst_seg", 32'(seg), 32'h7F);
    chk("rst_fd", 32'(frame_done), 32'd0);
    rst = 1'b0;
    tick;
    chk("first_fd", 32'(frame_done), 32'd1);
    tick;
    chk("first_an", 32'(an), 32'hE);
    chk("first_seg", 32'(seg), 32'h40);
    sync_frame;
    check_frame(7'h40, 7'h79, 7'h7F, 7'h7F, 3, -1, 16'h0);
    check_frame(7'h40, 7'h79, 7'h7F, 7'h7F, 3, -1, 16'h0);
    load(16'h1234, 1'b0, 2'd3);
    check_frame(7'h19, 7'h30, 7'h24, 7'h79, 3, -1, 16'h0);
    load(16'h5678, 1'b0, 2'd3);
    check_frame(7'h00, 7'h78, 7'h02, 7'h12, 3, -1, 16'h0);
    load(16'hEDCB, 1'b0, 2'd3);
    check_frame(7'h03, 7'h46, 7'h21, 7'h06, 3, -1, 16'h0);
    load(16'h0009, 1'b1, 2'd3);
    check_frame(7'h10, 7'h7F, 7'h7F, 7'h7F, 3, -1, 16'h0);
    load(16'h0000, 1'b1, 2'd3);
    check_frame(7'h40, 7'h7F, 7'h7F, 7'h7F, 3, -1, 16'h0);
    load(16'h0102, 1'b1, 2'd3);
    check_frame(7'h24, 7'h40, 7'h79, 7'h7F, 3, -1, 16'h0);
    load(16'h0F0A, 1'b1, 2'd3);
    check_frame(7'h08, 7'h7F, 7'h7F, 7'h7F, 3, -1, 16'h0);
    load(16'h0000, 1'b0, 2'd1);
    check_frame(7'h40, 7'h40, 7'h40, 7'h40, 1, -1, 16'h0);
    load(16'h0000, 1'b0, 2'd0);
    check_frame(7'h40, 7'h40, 7'h40, 7'h40, 0, -1, 16'h0);
    load(16'h0010, 1'b0, 2'd3);
    check_frame(7'h40, 7'h79, 7'h40, 7'h40, 3, 8, 16'h0009);
    check_frame(7'h10, 7'h40, 7'h40, 7'h40, 3, 2, 16'h0008);
    check_frame(7'h00, 7'h40, 7'h40, 7'h40, 3, -1, 16'h0);
    load(16'h0102, 1'b0, 2'd3);
    e6 = '{7'h24, 7'h40, 7'h79, 7'h40};
    for (int k = 0; k < 40; k++) begin
      scan_en = (k % 4 == 3);
      tick;
      t = k / 4;
      ea = ~(4'b0001 << (t / 4));
      chk("slow_an", 32'(an), 32'(ea));
      chk("slow_seg", 32'(seg), 32'(e6[t/4]));
      chk("slow_fd", 32'(frame_done), 32'd0);
    end
    rst = 1'b1;
    scan_en = 1'b0;
    tick;
    chk("midrst_an", 32'(an), 32'hF);
    chk("midrst_seg", 32'(seg), 32'h7F);
    chk("midrst_fd", 32'(frame_done), 32'd0);
    rst = 1'b0;
    tick;
    chk("hold_seg", 32'(seg), 32'h7F);
    chk("hold_fd", 32'(frame_done), 32'd0);
    tick;
    chk("hold_seg2", 32'(seg), 32'h7F);
    chk("hold_fd2", 32'(frame_done), 32'd0);
    scan_en = 1'b1;
    tick;
    chk("reload_fd", 32'(frame_done), 32'd1);
`ifdef SEVENSEG_DP_EN
    dp_in = 4'b0010;
    load(16'h1234, 1'b0, 2'd1);
    for (int j = 0; j < 16; j++) begin
      tick;
      chk("dp_n", 32'(dp_n), (j / 4 == 1 && j % 4 <= 1) ? 32'd0 : 32'd1);
    end
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
